// File: rtl/stream_demux_1to2_if.sv
// Valid/ready bundle for the 1-to-2 stream demux: one input stream, two output streams.
interface stream_demux_1to2_if #(
  parameter int unsigned D = 1
);
  logic [D-1:0] in_data;
  logic         in_last;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;

  logic [D-1:0] a_data;
  logic         a_last;
  logic         a_valid;
  logic         a_ready;

  logic [D-1:0] b_data;
  logic         b_last;
  logic         b_valid;
  logic         b_ready;

  modport master (
    output in_data, in_last, in_sel, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_last, a_valid, b_data, b_last, b_valid
  );

  modport slave (
    input  in_data, in_last, in_sel, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_last, a_valid, b_data, b_last, b_valid
  );
endinterface

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demultiplexer; route is locked per packet, one-entry
// output slot and completed-packet counter per output.
module stream_demux_1to2 #(
  parameter int unsigned D  = 1,
  parameter int unsigned CW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_demux_1to2_if.slave   bus,
  output logic [CW-1:0]        a_pkt_cnt,
  output logic [CW-1:0]        b_pkt_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic         target_a;
  logic         ready_c;
  logic         accept;
  logic         load_a;
  logic         load_b;

  logic [D-1:0] a_data_q;
  logic         a_last_q;
  logic         a_valid_q;
  logic [D-1:0] b_data_q;
  logic         b_last_q;
  logic         b_valid_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: lock the route on a first beat that is not also the last
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !bus.in_last) state_nxt = target_a ? ROUTE_A : ROUTE_B;
      end
      ROUTE_A, ROUTE_B: begin
        if (accept && bus.in_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: target selection and input acceptance
  always_comb begin
    target_a = 1'b0;
    case (state)
      IDLE:    target_a = bus.in_sel;
      ROUTE_A: target_a = 1'b1;
      ROUTE_B: target_a = 1'b0;
      default: target_a = 1'b0;
    endcase
    ready_c = target_a ? (!a_valid_q || bus.a_ready) : (!b_valid_q || bus.b_ready);
    accept  = bus.in_valid && ready_c;
    load_a  = accept && target_a;
    load_b  = accept && !target_a;
  end

  // Output slot A and its packet counter
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_last_q  <= 1'b0;
      a_pkt_cnt <= '0;
    end else begin
      if (load_a) begin
        a_valid_q <= 1'b1;
        a_data_q  <= bus.in_data;
        a_last_q  <= bus.in_last;
      end else if (bus.a_ready) begin
        a_valid_q <= 1'b0;
      end
      if (a_valid_q && bus.a_ready && a_last_q) a_pkt_cnt <= a_pkt_cnt + CW'(1);
    end
  end

  // Output slot B and its packet counter
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_last_q  <= 1'b0;
      b_pkt_cnt <= '0;
    end else begin
      if (load_b) begin
        b_valid_q <= 1'b1;
        b_data_q  <= bus.in_data;
        b_last_q  <= bus.in_last;
      end else if (bus.b_ready) begin
        b_valid_q <= 1'b0;
      end
      if (b_valid_q && bus.b_ready && b_last_q) b_pkt_cnt <= b_pkt_cnt + CW'(1);
    end
  end

  // busy mirrors the registered state being away from IDLE
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_nxt != IDLE);
  end

  assign bus.in_ready = ready_c;
  assign bus.a_data   = a_data_q;
  assign bus.a_last   = a_last_q;
  assign bus.a_valid  = a_valid_q;
  assign bus.b_data   = b_data_q;
  assign bus.b_last   = b_last_q;
  assign bus.b_valid  = b_valid_q;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2: directed vector table, hand sequences for wrap and
// mid-packet reset, then randomized traffic against a queue-based reference.
module tb_stream_demux_1to2;

  localparam int unsigned D  = 8;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] a_pkt_cnt;
  logic [CW-1:0] b_pkt_cnt;
  logic          busy;

  int total = 0;
  int bad   = 0;

  stream_demux_1to2_if #(.D(D)) bus ();

  stream_demux_1to2 #(.D(D), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .a_pkt_cnt (a_pkt_cnt),
    .b_pkt_cnt (b_pkt_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, s, l;
    logic [7:0] d;
    logic       ar, br;
    logic       e_rdy;
    logic       e_av;
    logic [7:0] e_ad;
    logic       e_al;
    logic       e_bv;
    logic [7:0] e_bd;
    logic       e_bl;
    logic [1:0] e_ac, e_bc;
    logic       e_busy;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic l, input logic [7:0] d,
                       input logic ar, input logic br);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_last  = l;
    bus.in_data  = d;
    bus.a_ready  = ar;
    bus.b_ready  = br;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_a_valid"}, 32'(bus.a_valid), 32'd0);
    chk({tag, "_b_valid"}, 32'(bus.b_valid), 32'd0);
    chk({tag, "_a_cnt"},   32'(a_pkt_cnt),   32'd0);
    chk({tag, "_b_cnt"},   32'(b_pkt_cnt),   32'd0);
    chk({tag, "_busy"},    32'(busy),        32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Reference model state: expected slot contents as queues of {last,data}
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  bit         m_mid;
  bit         m_ra;
  int         ca, cb;

  initial begin
    // route lock, backpressure, interleave
    vecs[0]  = '{1,1,0,8'h11, 1,0, 1, 1,8'h11,0, 0,8'h00,0, 0,0, 1};
    vecs[1]  = '{1,0,0,8'h22, 1,0, 1, 1,8'h22,0, 0,8'h00,0, 0,0, 1};
    vecs[2]  = '{1,1,1,8'h33, 1,0, 1, 1,8'h33,1, 0,8'h00,0, 0,0, 0};
    vecs[3]  = '{0,0,0,8'h00, 1,0, 1, 0,8'h00,0, 0,8'h00,0, 1,0, 0};
    vecs[4]  = '{1,0,0,8'h44, 1,0, 1, 0,8'h00,0, 1,8'h44,0, 1,0, 1};
    vecs[5]  = '{1,0,1,8'h55, 1,0, 0, 0,8'h00,0, 1,8'h44,0, 1,0, 1};
    vecs[6]  = '{1,0,1,8'h55, 1,1, 1, 0,8'h00,0, 1,8'h55,1, 1,0, 0};
    vecs[7]  = '{0,0,0,8'h00, 1,1, 1, 0,8'h00,0, 0,8'h00,0, 1,1, 0};
    vecs[8]  = '{1,1,1,8'h66, 0,1, 1, 1,8'h66,1, 0,8'h00,0, 1,1, 0};
    vecs[9]  = '{1,0,1,8'h77, 0,1, 1, 1,8'h66,1, 1,8'h77,1, 1,1, 0};
    vecs[10] = '{0,0,0,8'h00, 0,1, 1, 1,8'h66,1, 0,8'h00,0, 1,2, 0};
    vecs[11] = '{0,0,0,8'h00, 1,1, 1, 0,8'h00,0, 0,8'h00,0, 2,2, 0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();
    chk_idle("reset0");

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].l, vecs[i].d, vecs[i].ar, vecs[i].br);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_a_valid", i), 32'(bus.a_valid), 32'(vecs[i].e_av));
      chk($sformatf("vec%0d_b_valid", i), 32'(bus.b_valid), 32'(vecs[i].e_bv));
      if (vecs[i].e_av) begin
        chk($sformatf("vec%0d_a_data", i), 32'(bus.a_data), 32'(vecs[i].e_ad));
        chk($sformatf("vec%0d_a_last", i), 32'(bus.a_last), 32'(vecs[i].e_al));
      end
      if (vecs[i].e_bv) begin
        chk($sformatf("vec%0d_b_data", i), 32'(bus.b_data), 32'(vecs[i].e_bd));
        chk($sformatf("vec%0d_b_last", i), 32'(bus.b_last), 32'(vecs[i].e_bl));
      end
      chk($sformatf("vec%0d_a_cnt", i), 32'(a_pkt_cnt), 32'(vecs[i].e_ac));
      chk($sformatf("vec%0d_b_cnt", i), 32'(b_pkt_cnt), 32'(vecs[i].e_bc));
      chk($sformatf("vec%0d_busy", i),  32'(busy),      32'(vecs[i].e_busy));
    end

    // Counter wrap: back-to-back single-beat packets to A
    do_reset();
    begin
      logic [1:0] exp_cnt[5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      drive(1'b1, 1'b1, 1'b1, 8'hA0, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        drive(k < 4 ? 1'b1 : 1'b0, 1'b1, 1'b1, 8'(8'hA1 + k), 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("wrap%0d_a_cnt", k), 32'(a_pkt_cnt), 32'(exp_cnt[k]));
      end
    end

    // Reset while locked to B with a held beat
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_pre_b_valid", 32'(bus.b_valid), 32'd1);
    chk("midrst_pre_busy",    32'(busy),        32'd1);
    do_reset();
    chk_idle("midrst");
    drive(1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_a_valid", 32'(bus.a_valid), 32'd1);
    chk("midrst_a_data",  32'(bus.a_data),  32'h99);
    chk("midrst_b_valid", 32'(bus.b_valid), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    qa.delete(); qb.delete();
    m_mid = 0; m_ra = 0; ca = 0; cb = 0;
    for (int n = 0; n < 3000; n++) begin
      logic v, s, l, ar, br, tgt, exp_rdy, acc;
      logic [7:0] d;
      logic [8:0] beat;
      v  = ($urandom_range(0, 9) < 7);
      s  = 1'($urandom_range(0, 1));
      l  = ($urandom_range(0, 9) < 3);
      d  = 8'($urandom);
      ar = ($urandom_range(0, 9) < 6);
      br = ($urandom_range(0, 9) < 6);
      drive(v, s, l, d, ar, br);
      #1;
      tgt     = m_mid ? m_ra : s;
      exp_rdy = tgt ? (qa.size() == 0 || ar) : (qb.size() == 0 || br);
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      acc = v && exp_rdy;
      @(posedge clk);
      if (qa.size() != 0 && ar) begin
        beat = qa.pop_front();
        if (beat[8]) ca++;
      end
      if (qb.size() != 0 && br) begin
        beat = qb.pop_front();
        if (beat[8]) cb++;
      end
      if (acc) begin
        if (tgt) qa.push_back({l, d});
        else     qb.push_back({l, d});
        if (l) m_mid = 0;
        else if (!m_mid) begin
          m_mid = 1;
          m_ra  = tgt;
        end
      end
      @(negedge clk);
      chk("rnd_a_valid", 32'(bus.a_valid), 32'(qa.size() != 0));
      chk("rnd_b_valid", 32'(bus.b_valid), 32'(qb.size() != 0));
      if (qa.size() != 0) chk("rnd_a_beat", 32'({bus.a_last, bus.a_data}), 32'(qa[0]));
      if (qb.size() != 0) chk("rnd_b_beat", 32'({bus.b_last, bus.b_data}), 32'(qb[0]));
      chk("rnd_a_cnt", 32'(a_pkt_cnt), 32'(ca % 4));
      chk("rnd_b_cnt", 32'(b_pkt_cnt), 32'(cb % 4));
      chk("rnd_busy",  32'(busy),      32'(m_mid));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
